multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 87 ++++++++
 rtl/multicycle_ctrl_out_dec.sv | 80 ++++++++
 rtl/multicycle_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared definitions for the multicycle controller: opcode and funct3 values,
// the 4-bit state enum, ALU operation codes, register write-data selects, the
// control bundle produced by the output decoder, and the DECODE next-state rule.
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    // Opcodes understood by the controller
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct3 values of interest
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_SHIFT_R = 3'b101;  // srli/srai share funct3

    // ALU operations driven directly by the controller
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    // Register write-data source select
    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_IMM = 2'd1;
    localparam logic [1:0] WSEL_MEM = 2'd2;

    // IDLE must stay at 0: the debug state port reads 0 while in reset.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC_R = 4'd3,
        ST_EXEC_I = 4'd4,
        ST_WB_ALU = 4'd5,
        ST_LUI    = 4'd6,
        ST_ADDR   = 4'd7,
        ST_MEM_RD = 4'd8,
        ST_WB_MEM = 4'd9,
        ST_MEM_WR = 4'd10,
        ST_BRANCH = 4'd11,
        ST_TRAP   = 4'd12
    } state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       rs2_imm_s;
        logic [1:0] w_data_s;
        logic       reg_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
    } ctrl_t;

    // State following DECODE; optional instruction groups trap when disabled.
    function automatic state_t decode_next(input logic [6:0] opcode,
                                           input logic [2:0] funct3,
                                           input logic       en_mem,
                                           input logic       en_branch);
        state_t nxt;
        nxt = ST_TRAP;
        case (opcode)
            OP_RTYPE: nxt = ST_EXEC_R;
            OP_ITYPE: nxt = ST_EXEC_I;
            OP_LUI:   nxt = ST_LUI;
            OP_LOAD, OP_STORE: begin
                if (en_mem && funct3 == F3_WORD)
                    nxt = ST_ADDR;
            end
            OP_BRANCH: begin
                if (en_branch && (funct3 == F3_BEQ || funct3 == F3_BNE))
                    nxt = ST_BRANCH;
            end
            default: ;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_out_dec.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ctrl_out_dec
// Combinational state-to-control decode for multicycle_ctrl. Every control is
// 0 unless the current state asserts it.
// Ports:
//   state     in  current controller state
//   funct3    in  instruction funct3 field
//   funct7_b5 in  instruction funct7 bit 5 (sub/sra selector)
//   zero      in  ALU zero flag (branch resolution)
//   ctrl      out decoded control bundle
// -----------------------------------------------------------------------------
module ctrl_out_dec
    import multicycle_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.pc_write = 1'b1;
                ctrl.ir_write = 1'b1;
                ctrl.pc_src   = 1'b0;
            end
            ST_EXEC_R: begin
                ctrl.rs2_imm_s = 1'b0;
                ctrl.alu_op    = {funct7_b5, funct3};
            end
            ST_EXEC_I: begin
                ctrl.rs2_imm_s = 1'b1;
                // Only the shift-right group uses funct7[5] (srli vs srai);
                // for other immediates that bit is part of the immediate.
                ctrl.alu_op = (funct3 == F3_SHIFT_R) ? {funct7_b5, funct3}
                                                     : {1'b0, funct3};
            end
            ST_WB_ALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.w_data_s  = WSEL_ALU;
            end
            ST_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.w_data_s  = WSEL_IMM;
            end
            ST_ADDR: begin
                ctrl.rs2_imm_s = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.alu_op   = ALU_ADD;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_WB_MEM: begin
                ctrl.reg_write = 1'b1;
                ctrl.w_data_s  = WSEL_MEM;
            end
            ST_BRANCH: begin
                ctrl.rs2_imm_s = 1'b0;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = 1'b1;
                ctrl.pc_write  = (funct3 == F3_BEQ && zero) ||
                                 (funct3 == F3_BNE && !zero);
            end
            ST_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multicycle instruction sequencer: state register, next-state logic and the
// memory wait counter, with controls decoded from the current state by
// ctrl_out_dec. TRAP (illegal instruction or memory timeout) holds until reset.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   opcode/funct3/funct7    instruction fields (held by the IR)
//   zero                    ALU zero flag
//   mem_ready               data memory access complete
//   alu_op .. mem_write     datapath controls
//   illegal                 sticky illegal/timeout flag
//   state                   current state, for debug
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 4,
    parameter int EN_MEM      = 1,
    parameter int EN_BRANCH   = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                zero,
    input  logic                mem_ready,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                rs2_imm_s,
    output logic [1:0]          w_data_s,
    output logic                reg_write,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                mem_read,
    output logic                mem_write,
    output logic                illegal,
    output logic [3:0]          state
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             wait_expired;
    ctrl_t            ctrl;

    // Only funct7[5] carries meaning for this controller.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // The cycle that would bring the count to MEM_TIMEOUT is the last one
    // allowed; mem_ready in that same cycle still completes normally.
    assign wait_expired = (wait_cnt_reg == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;  // any non-wait state clears, so entry starts at 0
        case (state_reg)
            ST_IDLE:   state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: state_next = decode_next(opcode, funct3,
                                                EN_MEM != 0, EN_BRANCH != 0);
            ST_EXEC_R,
            ST_EXEC_I: state_next = ST_WB_ALU;
            ST_WB_ALU,
            ST_LUI,
            ST_WB_MEM,
            ST_BRANCH: state_next = ST_FETCH;
            ST_ADDR:   state_next = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD,
            ST_MEM_WR: begin
                if (mem_ready)
                    state_next = (state_reg == ST_MEM_RD) ? ST_WB_MEM : ST_FETCH;
                else if (wait_expired)
                    state_next = ST_TRAP;
                else
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
            end
            ST_TRAP:   state_next = ST_TRAP;
            default:   state_next = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    ctrl_out_dec u_ctrl_out_dec (
        .state     (state_reg),
        .funct3    (funct3),
        .funct7_b5 (funct7[5]),
        .zero      (zero),
        .ctrl      (ctrl)
    );

    assign alu_op    = ALU_OP_W'(ctrl.alu_op);
    assign rs2_imm_s = ctrl.rs2_imm_s;
    assign w_data_s  = ctrl.w_data_s;
    assign reg_write = ctrl.reg_write;
    assign ir_write  = ctrl.ir_write;
    assign pc_write  = ctrl.pc_write;
    assign pc_src    = ctrl.pc_src;
    assign mem_read  = ctrl.mem_read;
    assign mem_write = ctrl.mem_write;
    assign illegal   = ctrl.illegal;
    assign state     = state_reg;

endmodule
